// File: rtl/lp_pkg.sv
// Shared types and helpers for the LP solver stimulus transmitter.
package lp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lp_state_e;

  typedef struct packed {
    logic signed [5:0]  a1;
    logic signed [5:0]  a2;
    logic signed [11:0] b;
  } lp_row_t;

  localparam logic signed [11:0] S12_MIN   = 12'sh800;
  localparam logic signed [11:0] S12_MAX   = 12'sh7FF;
  localparam logic [2:0]         LAST_BEAT = 3'd6;

  // The solver classifies (+-1,0) and (0,+-1) rows as box bounds.
  function automatic logic is_bound_row(input logic signed [5:0] a1,
                                        input logic signed [5:0] a2);
    logic a1_unit;
    logic a2_unit;
    a1_unit = (a1 == 6'sd1) || (a1 == 6'sh3F);
    a2_unit = (a2 == 6'sd1) || (a2 == 6'sh3F);
    return (a1_unit && (a2 == 6'sd0)) || ((a1 == 6'sd0) && a2_unit);
  endfunction

  function automatic logic signed [11:0] sat_neg12(input logic signed [11:0] v);
    return (v == S12_MIN) ? S12_MAX : -v;
  endfunction

endpackage

// File: rtl/lp_row_sel.sv
// Picks the constraint row carried by a SEND beat, applying the row rotation.
module lp_row_sel
  import lp_pkg::*;
(
  input  logic signed [11:0] x_lo,
  input  logic signed [11:0] x_hi,
  input  logic signed [11:0] y_lo,
  input  logic signed [11:0] y_hi,
  input  lp_row_t            g0,
  input  lp_row_t            g1,
  input  logic [2:0]         rot,
  input  logic [2:0]         beat,
  output lp_row_t            row,
  output logic               sat,
  output logic               miscls
);

  logic [2:0] rot_eff;
  logic [3:0] idx;

  // Row index = (beat - 1 + rot) mod 6, with rot 6/7 treated as 0.
  always_comb begin
    rot_eff = (rot >= 3'd6) ? 3'd0 : rot;
    idx     = {1'b0, beat} - 4'd1 + {1'b0, rot_eff};
    if (idx >= 4'd6) begin
      idx = idx - 4'd6;
    end else begin
      idx = idx;
    end
    row    = '0;
    sat    = 1'b0;
    miscls = 1'b0;
    case (idx)
      4'd0: begin
        row.a1 = 6'sd1;
        row.b  = x_hi;
      end
      4'd1: begin
        row.a1 = 6'sh3F;
        row.b  = sat_neg12(x_lo);
        sat    = (x_lo == S12_MIN);
      end
      4'd2: begin
        row.a2 = 6'sd1;
        row.b  = y_hi;
      end
      4'd3: begin
        row.a2 = 6'sh3F;
        row.b  = sat_neg12(y_lo);
        sat    = (y_lo == S12_MIN);
      end
      4'd4: begin
        row    = g0;
        miscls = is_bound_row(g0.a1, g0.a2);
      end
      4'd5: begin
        row    = g1;
        miscls = is_bound_row(g1.a1, g1.a2);
      end
      default: begin
        row = '0;
      end
    endcase
  end

endmodule

// File: rtl/lp_stim_tx.sv
// Serialises one latched LP problem to the solver and checks its reported optimum.
module lp_stim_tx
  import lp_pkg::*;
#(
  parameter int TIMEOUT = 1048576,
  parameter int TW      = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [5:0]  obj_c1,
  input  logic signed [5:0]  obj_c2,
  input  logic signed [11:0] x_lo,
  input  logic signed [11:0] x_hi,
  input  logic signed [11:0] y_lo,
  input  logic signed [11:0] y_hi,
  input  logic signed [5:0]  g0_a1,
  input  logic signed [5:0]  g0_a2,
  input  logic signed [5:0]  g1_a1,
  input  logic signed [5:0]  g1_a2,
  input  logic signed [11:0] g0_b,
  input  logic signed [11:0] g1_b,
  input  logic [2:0]         rot,
  input  logic signed [11:0] exp_max,
  output logic               lp_in_valid,
  output logic signed [5:0]  lp_in_a1,
  output logic signed [5:0]  lp_in_a2,
  output logic signed [11:0] lp_in_b,
  input  logic               lp_out_valid,
  input  logic signed [11:0] lp_out_max_value,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic               cfg_err,
  output logic signed [11:0] result
);

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  lp_state_e          state_q, state_d;
  logic [2:0]         beat_q, beat_d, rot_q, rot_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic signed [11:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic signed [11:0] exp_max_q, exp_max_d, result_q, result_d;
  lp_row_t            g0_q, g0_d, g1_q, g1_d, lp_in_q, lp_in_d;
  logic               lp_in_valid_q, lp_in_valid_d, busy_q, busy_d, done_q, done_d;
  logic               pass_q, pass_d, timeout_q, timeout_d, cfg_err_q, cfg_err_d;
  lp_row_t            sel_row;
  logic               sel_sat, sel_miscls;

  lp_row_sel u_row_sel (
    .x_lo   (x_lo_q),
    .x_hi   (x_hi_q),
    .y_lo   (y_lo_q),
    .y_hi   (y_hi_q),
    .g0     (g0_q),
    .g1     (g1_q),
    .rot    (rot_q),
    .beat   (beat_q),
    .row    (sel_row),
    .sat    (sel_sat),
    .miscls (sel_miscls)
  );

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    cnt_d         = cnt_q;
    rot_d         = rot_q;
    x_lo_d        = x_lo_q;
    x_hi_d        = x_hi_q;
    y_lo_d        = y_lo_q;
    y_hi_d        = y_hi_q;
    g0_d          = g0_q;
    g1_d          = g1_q;
    exp_max_d     = exp_max_q;
    lp_in_valid_d = 1'b0;
    lp_in_d       = '0;
    done_d        = 1'b0;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    cfg_err_d     = cfg_err_q;
    result_d      = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_lo_d        = x_lo;
          x_hi_d        = x_hi;
          y_lo_d        = y_lo;
          y_hi_d        = y_hi;
          g0_d          = {g0_a1, g0_a2, g0_b};
          g1_d          = {g1_a1, g1_a2, g1_b};
          rot_d         = rot;
          exp_max_d     = exp_max;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          cfg_err_d     = 1'b0;
          result_d      = 12'sd0;
          cnt_d         = '0;
          // Beat 0 goes out straight from the inputs, so rows start at beat 1.
          beat_d        = 3'd1;
          lp_in_valid_d = 1'b1;
          lp_in_d       = {obj_c1, obj_c2, 12'sd0};
          state_d       = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        lp_in_valid_d = 1'b1;
        lp_in_d       = sel_row;
        cfg_err_d     = cfg_err_q | sel_sat | sel_miscls;
        if (beat_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (lp_out_valid) begin
          result_d = lp_out_max_value;
          pass_d   = (lp_out_max_value == exp_max_q) && !cfg_err_q;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = 12'sd0;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_q        <= 3'd0;
      cnt_q         <= '0;
      rot_q         <= 3'd0;
      x_lo_q        <= 12'sd0;
      x_hi_q        <= 12'sd0;
      y_lo_q        <= 12'sd0;
      y_hi_q        <= 12'sd0;
      g0_q          <= '0;
      g1_q          <= '0;
      exp_max_q     <= 12'sd0;
      lp_in_valid_q <= 1'b0;
      lp_in_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      result_q      <= 12'sd0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      cnt_q         <= cnt_d;
      rot_q         <= rot_d;
      x_lo_q        <= x_lo_d;
      x_hi_q        <= x_hi_d;
      y_lo_q        <= y_lo_d;
      y_hi_q        <= y_hi_d;
      g0_q          <= g0_d;
      g1_q          <= g1_d;
      exp_max_q     <= exp_max_d;
      lp_in_valid_q <= lp_in_valid_d;
      lp_in_q       <= lp_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      cfg_err_q     <= cfg_err_d;
      result_q      <= result_d;
    end
  end

  assign lp_in_valid = lp_in_valid_q;
  assign lp_in_a1    = lp_in_q.a1;
  assign lp_in_a2    = lp_in_q.a2;
  assign lp_in_b     = lp_in_q.b;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign cfg_err     = cfg_err_q;
  assign result      = result_q;

endmodule

// File: tb/tb_lp_stim_tx.sv
// Directed bench for lp_stim_tx: frame order, rotation, compare, timeout, config errors, reset.
module tb_lp_stim_tx;

  logic clk = 1'b0;
  logic rst, start, lp_out_valid;
  logic signed [5:0]  obj_c1, obj_c2, g0_a1, g0_a2, g1_a1, g1_a2, lp_in_a1, lp_in_a2;
  logic signed [11:0] x_lo, x_hi, y_lo, y_hi, g0_b, g1_b, exp_max, lp_in_b;
  logic signed [11:0] lp_out_max_value, result;
  logic [2:0] rot;
  logic lp_in_valid, busy, done, pass, timeout, cfg_err;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] obs [0:7];
  logic [24:0] rows_m [0:5];
  logic done_seen;

  lp_stim_tx #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .obj_c1(obj_c1), .obj_c2(obj_c2),
    .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
    .g0_a1(g0_a1), .g0_a2(g0_a2), .g1_a1(g1_a1), .g1_a2(g1_a2),
    .g0_b(g0_b), .g1_b(g1_b), .rot(rot), .exp_max(exp_max),
    .lp_in_valid(lp_in_valid), .lp_in_a1(lp_in_a1), .lp_in_a2(lp_in_a2), .lp_in_b(lp_in_b),
    .lp_out_valid(lp_out_valid), .lp_out_max_value(lp_out_max_value),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .cfg_err(cfg_err),
    .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] mk(input int a1, input int a2, input int b);
    return {1'b1, a1[5:0], a2[5:0], b[11:0]};
  endfunction

  function automatic logic [24:0] exp_beat(input int k, input int r);
    if (k == 0) return mk(1, 1, 0);
    if (k == 7) return 25'd0;
    return rows_m[(k - 1 + r) % 6];
  endfunction

  // Test-plan problem and its hand-derived rows.
  task automatic set_base(input logic [2:0] r, input logic signed [11:0] em);
    obj_c1 = 6'sd1;  obj_c2 = 6'sd1;
    x_lo = 12'sd0;   x_hi = 12'sd3;  y_lo = 12'sd0;  y_hi = 12'sd3;
    g0_a1 = 6'sd1;   g0_a2 = 6'sd1;  g0_b = 12'sd4;
    g1_a1 = 6'sd1;   g1_a2 = -6'sd1; g1_b = 12'sd2;
    rot = r;         exp_max = em;
    rows_m[0] = mk(1, 0, 3);  rows_m[1] = mk(-1, 0, 0);
    rows_m[2] = mk(0, 1, 3);  rows_m[3] = mk(0, -1, 0);
    rows_m[4] = mk(1, 1, 4);  rows_m[5] = mk(1, -1, 2);
  endtask

  task automatic send_capture(input bit hold);
    start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs[k] = {lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b};
      done_seen = done_seen | done;
      lp_out_valid = (hold && k == 2);
      if (k != 7) tick;
    end
    start = 1'b0;
    lp_out_valid = 1'b0;
  endtask

  task automatic respond(input logic signed [11:0] val);
    lp_out_max_value = val;
    lp_out_valid = 1'b1;
    tick;
    lp_out_valid = 1'b0;
    lp_out_max_value = 12'sd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++;
    if ({lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b, busy, done, pass, timeout, cfg_err, result} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_outputs got valid=%b a1=%0d a2=%0d b=%0d busy=%b done=%b pass=%b to=%b cfg=%b res=%0d, all 0 required",
               lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b, busy, done, pass, timeout, cfg_err, result);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_rot0;
    set_base(3'd0, 12'sd4);
    send_capture(1'b0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (obs[k] !== exp_beat(k, 0)) begin
        n_err++;
        $display("FAIL rot0_beat%0d got %h required %h", k, obs[k], exp_beat(k, 0));
      end
    end
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rot0_wait_busy got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err, result} !== {4'b1100, 12'sd4}) begin
      n_err++;
      $display("FAIL rot0_status got done=%b pass=%b to=%b cfg=%b res=%0d required 1 1 0 0 4",
               done, pass, timeout, cfg_err, result);
    end
    tick;
    n_vec++;
    if ({busy, done, pass, result} !== {3'b001, 12'sd4}) begin
      n_err++;
      $display("FAIL rot0_hold got busy=%b done=%b pass=%b res=%0d required 0 0 1 4", busy, done, pass, result);
    end
  endtask

  task automatic test_rot(input logic [2:0] r, input int r_eff);
    set_base(r, 12'sd4);
    send_capture(1'b0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (obs[k] !== exp_beat(k, r_eff)) begin
        n_err++;
        $display("FAIL rot%0d_beat%0d got %h required %h", r, k, obs[k], exp_beat(k, r_eff));
      end
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err} !== 4'b1100) begin
      n_err++;
      $display("FAIL rot%0d_status got done=%b pass=%b to=%b cfg=%b required 1 1 0 0", r, done, pass, timeout, cfg_err);
    end
    tick;
  endtask

  task automatic test_mismatch;
    set_base(3'd0, 12'sd5);
    send_capture(1'b0);
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err, result} !== {4'b1000, 12'sd4}) begin
      n_err++;
      $display("FAIL mismatch_status got done=%b pass=%b to=%b cfg=%b res=%0d required 1 0 0 0 4",
               done, pass, timeout, cfg_err, result);
    end
    tick;
  endtask

  task automatic test_timeout;
    int n;
    set_base(3'd0, 12'sd4);
    send_capture(1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    // Last beat is in the cycle before capture ends; done is 16 cycles after it.
    n_vec++;
    if (n != 15) begin
      n_err++;
      $display("FAIL timeout_latency got %0d cycles after last beat required 16", n + 1);
    end
    n_vec++;
    if ({done, pass, timeout, cfg_err, result} !== {4'b1010, 12'sd0}) begin
      n_err++;
      $display("FAIL timeout_status got done=%b pass=%b to=%b cfg=%b res=%0d required 1 0 1 0 0",
               done, pass, timeout, cfg_err, result);
    end
    tick;
  endtask

  task automatic test_sat;
    set_base(3'd0, 12'sd4);
    x_lo = -12'sd2048;
    rows_m[1] = mk(-1, 0, 2047);
    send_capture(1'b0);
    n_vec++;
    if (obs[2] !== mk(-1, 0, 2047)) begin
      n_err++;
      $display("FAIL sat_r1 got %h required %h", obs[2], mk(-1, 0, 2047));
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err, result} !== {4'b1001, 12'sd4}) begin
      n_err++;
      $display("FAIL sat_status got done=%b pass=%b to=%b cfg=%b res=%0d required 1 0 0 1 4",
               done, pass, timeout, cfg_err, result);
    end
    tick;
  endtask

  task automatic test_bound_row;
    set_base(3'd0, 12'sd4);
    g0_a1 = 6'sd1; g0_a2 = 6'sd0; g0_b = 12'sd5;
    send_capture(1'b0);
    n_vec++;
    if (obs[5] !== mk(1, 0, 5)) begin
      n_err++;
      $display("FAIL bound_row_r4 got %h required %h", obs[5], mk(1, 0, 5));
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err, result} !== {4'b1001, 12'sd4}) begin
      n_err++;
      $display("FAIL bound_row_status got done=%b pass=%b to=%b cfg=%b res=%0d required 1 0 0 1 4",
               done, pass, timeout, cfg_err, result);
    end
    tick;
  endtask

  task automatic test_start_held;
    set_base(3'd0, 12'sd4);
    send_capture(1'b1);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (obs[k] !== exp_beat(k, 0)) begin
        n_err++;
        $display("FAIL held_beat%0d got %h required %h", k, obs[k], exp_beat(k, 0));
      end
    end
    n_vec++;
    if (done_seen !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL held_send_out_valid got done_seen=%b done=%b required 0 0", done_seen, done);
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass} !== 2'b11) begin
      n_err++;
      $display("FAIL held_status got done=%b pass=%b required 1 1", done, pass);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    set_base(3'd0, 12'sd4);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    n_vec++;
    if ({lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b} !== mk(0, 1, 3)) begin
      n_err++;
      $display("FAIL rstmid_beat3 got %h required %h", {lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b}, mk(0, 1, 3));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_vec++;
    if ({lp_in_valid, lp_in_a1, lp_in_a2, lp_in_b, busy, done, pass, timeout, cfg_err, result} !== 42'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs got valid=%b b=%0d busy=%b done=%b, all 0 required", lp_in_valid, lp_in_b, busy, done);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick;
      done_seen = done_seen | done | lp_in_valid;
    end
    n_vec++;
    if (done_seen !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet got activity=%b required 0", done_seen);
    end
    send_capture(1'b0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (obs[k] !== exp_beat(k, 0)) begin
        n_err++;
        $display("FAIL rstmid_beat%0d got %h required %h", k, obs[k], exp_beat(k, 0));
      end
    end
    respond(12'sd4);
    n_vec++;
    if ({done, pass, timeout, cfg_err} !== 4'b1100) begin
      n_err++;
      $display("FAIL rstmid_status got done=%b pass=%b to=%b cfg=%b required 1 1 0 0", done, pass, timeout, cfg_err);
    end
    tick;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    lp_out_valid = 1'b0;
    lp_out_max_value = 12'sd0;
    set_base(3'd0, 12'sd0);
    test_reset;
    test_rot0;
    test_rot(3'd2, 2);
    test_rot(3'd7, 0);
    test_mismatch;
    test_timeout;
    test_sat;
    test_bound_row;
    test_start_held;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
